// File: rtl/ama_riscv_hazard_ctrl_pkg.sv
// Shared types for the hazard controller: FSM states, shadow stage entry, x0 index.
// Pure declarations, no timing or flow-control behaviour of its own.
package ama_riscv_hazard_ctrl_pkg;

   localparam int          REG_IDX_W  = 5;
   localparam logic [4:0]  RF_X0_ZERO = 5'd0;

   typedef enum logic [1:0] {
      HZ_RUN      = 2'd0,
      HZ_LU_STALL = 2'd1,
      HZ_MEM_WAIT = 2'd2
   } hz_state_e;

   typedef struct packed {
      logic                 v;
      logic [REG_IDX_W-1:0] rd;
      logic                 we;
      logic                 ld;
   } hz_entry_t;

   localparam hz_entry_t HZ_ENTRY_NOP = '0;

   // Invalid entries collapse to all-zero so downstream rd/we need no valid qualifier.
   function automatic hz_entry_t hz_sanitize(input hz_entry_t e);
      hz_entry_t r;
      r = e;
      if (!e.v) begin
         r = HZ_ENTRY_NOP;
      end else if (e.rd == RF_X0_ZERO) begin
         r.we = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/ama_riscv_hazard_ctrl_if.sv
// Bundle between core control/forwarding logic (master) and the hazard controller (slave).
// Wires only; the slave drives stall/flush combinationally and rd/we from flops.
interface ama_riscv_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             inst_valid_id;
   logic [4:0]       rs1_id;
   logic [4:0]       rs2_id;
   logic             rs1_used_id;
   logic             rs2_used_id;
   logic [4:0]       rd_id;
   logic             reg_we_id;
   logic             load_inst_id;
   logic             mispredict_ex;
   logic             dmem_ready;

   logic [4:0]       rd_ex;
   logic             reg_we_ex;
   logic [4:0]       rd_mem;
   logic             reg_we_mem;
   logic             stall_if;
   logic             stall_id;
   logic             stall_ex;
   logic             bubble_ex;
   logic             flush_id;
   logic             dmem_timeout;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output inst_valid_id, rs1_id, rs2_id, rs1_used_id, rs2_used_id,
             rd_id, reg_we_id, load_inst_id, mispredict_ex, dmem_ready,
      input  rd_ex, reg_we_ex, rd_mem, reg_we_mem, stall_if, stall_id,
             stall_ex, bubble_ex, flush_id, dmem_timeout, stall_cnt
   );

   modport slave (
      input  inst_valid_id, rs1_id, rs2_id, rs1_used_id, rs2_used_id,
             rd_id, reg_we_id, load_inst_id, mispredict_ex, dmem_ready,
      output rd_ex, reg_we_ex, rd_mem, reg_we_mem, stall_if, stall_id,
             stall_ex, bubble_ex, flush_id, dmem_timeout, stall_cnt
   );
endinterface

// File: rtl/ama_riscv_hazard_stage_reg.sv
// One shadow pipeline stage {v, rd, we, ld}; one-cycle load, hold has priority over clear.
// Hold freezes contents; clear loads a NOP; otherwise the sanitised input is captured.
module ama_riscv_hazard_stage_reg
   import ama_riscv_hazard_ctrl_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      hold,
   input  logic      clr,
   input  hz_entry_t d,
   output hz_entry_t q
);

   hz_entry_t ent_d;
   hz_entry_t ent_q;

   always_comb begin
      ent_d = ent_q;
      if (!hold) begin
         ent_d = clr ? HZ_ENTRY_NOP : hz_sanitize(d);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent_q <= HZ_ENTRY_NOP;
      end else begin
         ent_q <= ent_d;
      end
   end

   assign q = ent_q;

endmodule

// File: rtl/ama_riscv_hazard_ctrl.sv
// Tracks EX/MEM destinations for forwarding and resolves load-use, DMEM wait and mispredict.
// rd/we outputs lag one flop; stall/bubble/flush are same-cycle; DMEM wait freezes until dmem_ready.
module ama_riscv_hazard_ctrl
   import ama_riscv_hazard_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   ama_riscv_hazard_ctrl_if.slave hz
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   hz_state_e        state_d, state_q;
   logic [WAIT_W-1:0] wait_cnt_d, wait_cnt_q;
   logic [WAIT_W-1:0] wait_inc;
   logic             timeout_d, timeout_q;
   logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

   hz_entry_t id_ent;
   hz_entry_t ex_q;
   hz_entry_t mem_q;
   logic      ex_hold, ex_clr, mem_hold;
   logic      load_use, mem_freeze;
   logic      stall_if_c, stall_id_c, stall_ex_c, bubble_ex_c, flush_id_c;

   assign id_ent = '{v: hz.inst_valid_id, rd: hz.rd_id, we: hz.reg_we_id, ld: hz.load_inst_id};

   // The EX entry is a bubble while in LU_STALL, so the state gate only makes that explicit.
   assign load_use = (state_q != HZ_LU_STALL) && ex_q.v && ex_q.ld && ex_q.we &&
                     hz.inst_valid_id &&
                     ((hz.rs1_used_id && (hz.rs1_id == ex_q.rd)) ||
                      (hz.rs2_used_id && (hz.rs2_id == ex_q.rd)));

   // Same term enters and leaves MEM_WAIT, so a ready load never costs a cycle.
   assign mem_freeze = mem_q.v && mem_q.ld && !hz.dmem_ready;

   assign wait_inc = wait_cnt_q + WAIT_W'(1);

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      timeout_d   = timeout_q;
      stall_cnt_d = stall_cnt_q;
      stall_if_c  = 1'b0;
      stall_id_c  = 1'b0;
      stall_ex_c  = 1'b0;
      bubble_ex_c = 1'b0;
      flush_id_c  = 1'b0;
      ex_hold     = 1'b0;
      ex_clr      = 1'b0;
      mem_hold    = 1'b0;

      if (mem_freeze) begin
         stall_if_c = 1'b1;
         stall_id_c = 1'b1;
         stall_ex_c = 1'b1;
         ex_hold    = 1'b1;
         mem_hold   = 1'b1;
         state_d    = HZ_MEM_WAIT;
         if (wait_cnt_q != WAIT_W'(MEM_TIMEOUT)) begin
            wait_cnt_d = wait_inc;
         end
         if (wait_inc == WAIT_W'(MEM_TIMEOUT)) begin
            timeout_d = 1'b1;
         end
      end else begin
         wait_cnt_d = '0;
         state_d    = HZ_RUN;
         if (hz.mispredict_ex) begin
            flush_id_c  = 1'b1;
            bubble_ex_c = 1'b1;
            ex_clr      = 1'b1;
         end else if (load_use) begin
            stall_if_c  = 1'b1;
            stall_id_c  = 1'b1;
            bubble_ex_c = 1'b1;
            ex_clr      = 1'b1;
            state_d     = HZ_LU_STALL;
         end
      end

      if (stall_if_c && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= HZ_RUN;
         wait_cnt_q  <= '0;
         timeout_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         timeout_q   <= timeout_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   ama_riscv_hazard_stage_reg u_ex_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .hold  (ex_hold),
      .clr   (ex_clr),
      .d     (id_ent),
      .q     (ex_q)
   );

   ama_riscv_hazard_stage_reg u_mem_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .hold  (mem_hold),
      .clr   (1'b0),
      .d     (ex_q),
      .q     (mem_q)
   );

   assign hz.rd_ex        = ex_q.rd;
   assign hz.reg_we_ex    = ex_q.we;
   assign hz.rd_mem       = mem_q.rd;
   assign hz.reg_we_mem   = mem_q.we;
   assign hz.stall_if     = stall_if_c;
   assign hz.stall_id     = stall_id_c;
   assign hz.stall_ex     = stall_ex_c;
   assign hz.bubble_ex    = bubble_ex_c;
   assign hz.flush_id     = flush_id_c;
   assign hz.dmem_timeout = timeout_q;
   assign hz.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_ama_riscv_hazard_ctrl.sv
// Directed bench for the hazard controller: load-use, x0 load, DMEM wait, mispredict, timeout, reset.
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns after that.
module tb_ama_riscv_hazard_ctrl;

   localparam int CNT_W = 16;

   logic clk;
   logic rst_n;
   int   tests_run;
   int   tests_failed;

   ama_riscv_hazard_ctrl_if #(.CNT_W(CNT_W)) hz_if ();

   ama_riscv_hazard_ctrl #(
      .MEM_TIMEOUT (4),
      .CNT_W       (CNT_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic we, input logic ld);
      hz_if.inst_valid_id = v;
      hz_if.rs1_id        = rs1;
      hz_if.rs1_used_id   = u1;
      hz_if.rs2_id        = rs2;
      hz_if.rs2_used_id   = u2;
      hz_if.rd_id         = rd;
      hz_if.reg_we_id     = we;
      hz_if.load_inst_id  = ld;
   endtask

   task automatic idle_id();
      set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_id();
      hz_if.mispredict_ex = 1'b0;
      hz_if.dmem_ready    = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      do_reset();

      // Reset state
      settle();
      chk("rst_rd_ex",     32'(hz_if.rd_ex), 32'd0);
      chk("rst_we_ex",     32'(hz_if.reg_we_ex), 32'd0);
      chk("rst_rd_mem",    32'(hz_if.rd_mem), 32'd0);
      chk("rst_we_mem",    32'(hz_if.reg_we_mem), 32'd0);
      chk("rst_stalls",    32'({hz_if.stall_if, hz_if.stall_id, hz_if.stall_ex,
                                hz_if.bubble_ex, hz_if.flush_id}), 32'd0);
      chk("rst_timeout",   32'(hz_if.dmem_timeout), 32'd0);
      chk("rst_stall_cnt", 32'(hz_if.stall_cnt), 32'd0);

      // Load-use: lw x5 then add x6,x5,x1
      set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
      tick();
      chk("lu_rd_ex_load", 32'(hz_if.rd_ex), 32'd5);
      chk("lu_we_ex_load", 32'(hz_if.reg_we_ex), 32'd1);
      set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
      settle();
      chk("lu_stall_vec", 32'({hz_if.stall_if, hz_if.stall_id, hz_if.stall_ex,
                               hz_if.bubble_ex, hz_if.flush_id}), 32'b11010);
      tick();
      settle();
      chk("lu_rd_mem",     32'(hz_if.rd_mem), 32'd5);
      chk("lu_we_mem",     32'(hz_if.reg_we_mem), 32'd1);
      chk("lu_ex_bubble",  32'(hz_if.rd_ex), 32'd0);
      chk("lu_one_cycle",  32'({hz_if.stall_if, hz_if.stall_ex, hz_if.bubble_ex}), 32'd0);
      tick();
      chk("lu_rd_ex_dep",  32'(hz_if.rd_ex), 32'd6);
      chk("lu_we_ex_dep",  32'(hz_if.reg_we_ex), 32'd1);
      chk("lu_stall_cnt",  32'(hz_if.stall_cnt), 32'd1);

      // Load to x0 then a reader of x0: no hazard, write enable dropped
      set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
      tick();
      chk("x0_rd_ex", 32'(hz_if.rd_ex), 32'd0);
      chk("x0_we_ex", 32'(hz_if.reg_we_ex), 32'd0);
      set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0);
      settle();
      chk("x0_no_stall", 32'({hz_if.stall_if, hz_if.bubble_ex}), 32'd0);
      tick();
      idle_id();
      tick();
      chk("x0_stall_cnt", 32'(hz_if.stall_cnt), 32'd1);

      // DMEM wait: three cycles with dmem_ready low
      do_reset();
      set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
      tick();
      idle_id();
      tick();
      hz_if.dmem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk($sformatf("dw_stall_ex_%0d", i), 32'({hz_if.stall_if, hz_if.stall_id,
                                                   hz_if.stall_ex}), 32'b111);
         chk($sformatf("dw_rd_mem_%0d", i), 32'(hz_if.rd_mem), 32'd7);
         tick();
      end
      hz_if.dmem_ready = 1'b1;
      settle();
      chk("dw_release", 32'({hz_if.stall_if, hz_if.stall_ex}), 32'd0);
      chk("dw_rd_mem_rel", 32'(hz_if.rd_mem), 32'd7);
      tick();
      chk("dw_mem_moved",  32'(hz_if.rd_mem), 32'd0);
      chk("dw_stall_cnt",  32'(hz_if.stall_cnt), 32'd3);
      chk("dw_no_timeout", 32'(hz_if.dmem_timeout), 32'd0);

      // Mispredict coincident with load-use: flush wins, no stall
      do_reset();
      set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
      tick();
      set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
      hz_if.mispredict_ex = 1'b1;
      settle();
      chk("mp_vec", 32'({hz_if.stall_if, hz_if.stall_id, hz_if.stall_ex,
                         hz_if.bubble_ex, hz_if.flush_id}), 32'b00011);
      tick();
      hz_if.mispredict_ex = 1'b0;
      idle_id();
      chk("mp_ex_invalid", 32'({hz_if.rd_ex, hz_if.reg_we_ex}), 32'd0);
      chk("mp_ex_to_mem",  32'(hz_if.rd_mem), 32'd5);
      chk("mp_stall_cnt",  32'(hz_if.stall_cnt), 32'd0);

      // Timeout with MEM_TIMEOUT=4: dmem_ready low for 6 cycles
      do_reset();
      set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
      tick();
      idle_id();
      tick();
      hz_if.dmem_ready = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         if (i == 2) begin
            hz_if.mispredict_ex = 1'b1;
            settle();
            chk("to_mp_ignored", 32'({hz_if.flush_id, hz_if.bubble_ex, hz_if.stall_ex}), 32'b001);
         end
         tick();
         hz_if.mispredict_ex = 1'b0;
         if (i == 3) chk("to_not_yet", 32'(hz_if.dmem_timeout), 32'd0);
         if (i == 4) chk("to_raised",  32'(hz_if.dmem_timeout), 32'd1);
      end
      hz_if.dmem_ready = 1'b1;
      settle();
      chk("to_release", 32'(hz_if.stall_if), 32'd0);
      tick();
      chk("to_sticky",    32'(hz_if.dmem_timeout), 32'd1);
      chk("to_stall_cnt", 32'(hz_if.stall_cnt), 32'd6);

      // Async reset in the middle of MEM_WAIT
      set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
      tick();
      idle_id();
      tick();
      hz_if.dmem_ready = 1'b0;
      tick();
      tick();
      settle();
      chk("ar_pre_stall", 32'(hz_if.stall_ex), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("ar_stalls",    32'({hz_if.stall_if, hz_if.stall_id, hz_if.stall_ex,
                               hz_if.bubble_ex, hz_if.flush_id}), 32'd0);
      chk("ar_rd_we",     32'({hz_if.rd_ex, hz_if.reg_we_ex, hz_if.rd_mem, hz_if.reg_we_mem}), 32'd0);
      chk("ar_stall_cnt", 32'(hz_if.stall_cnt), 32'd0);
      chk("ar_timeout",   32'(hz_if.dmem_timeout), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("ar_run_state", 32'(dut.state_q), 32'(ama_riscv_hazard_ctrl_pkg::HZ_RUN));
      chk("ar_no_stall",  32'(hz_if.stall_if), 32'd0);
      hz_if.dmem_ready = 1'b1;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
